// File: rtl/serial_adder_if.sv
// Handshake bundle for the digit-serial adder: operand channel (in_*) and
// result channel (out_*), plus the busy status flag.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carryout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carryout, overflow, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple of
// full-adder slices, inter-digit carry in a flop, result after WIDTH/DIGIT cycles.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_sr_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             carryout_r;
    logic             overflow_r;
    logic [CW-1:0]    cnt_r;

    logic [DIGIT-1:0] dsum_s;
    logic             cout_s;
    logic             cmsb_s;
    logic             last_s;
    logic [WIDTH-1:0] sum_next_s;

    assign last_s     = (cnt_r == CW'(N - 1));
    assign sum_next_s = (sum_sr_r >> DIGIT) | (WIDTH'(dsum_s) << (WIDTH - DIGIT));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_s = BUSY;
                else              state_s = IDLE;
            end
            BUSY: begin
                if (last_s) state_s = DONE;
                else        state_s = BUSY;
            end
            DONE: begin
                if (bus.out_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Digit ripple; cmsb_s ends up as the carry into the top bit of the digit
    always_comb begin
        logic c;
        c      = carry_r;
        dsum_s = '0;
        cmsb_s = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            cmsb_s    = c;
            dsum_s[i] = a_sr_r[i] ^ b_sr_r[i] ^ c;
            c         = (a_sr_r[i] & b_sr_r[i]) | (b_sr_r[i] & c) | (c & a_sr_r[i]);
        end
        cout_s = c;
    end

    // Operand capture, digit-serial datapath and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r     <= '0;
            b_sr_r     <= '0;
            sum_sr_r   <= '0;
            sum_r      <= '0;
            carry_r    <= 1'b0;
            carryout_r <= 1'b0;
            overflow_r <= 1'b0;
            cnt_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr_r  <= bus.a;
                        b_sr_r  <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub;
                        cnt_r   <= '0;
                    end
                end
                BUSY: begin
                    a_sr_r   <= a_sr_r >> DIGIT;
                    b_sr_r   <= b_sr_r >> DIGIT;
                    sum_sr_r <= sum_next_s;
                    carry_r  <= cout_s;
                    cnt_r    <= last_s ? '0 : cnt_r + CW'(1);
                    // Output registers change only when a new result completes
                    if (last_s) begin
                        sum_r      <= sum_next_s;
                        carryout_r <= cout_s;
                        overflow_r <= cmsb_s ^ cout_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r == BUSY);
    assign bus.sum       = sum_r;
    assign bus.carryout  = carryout_r;
    assign bus.overflow  = overflow_r;
endmodule
